i2f_sched: RTL
==============

I2F_SCHED -- requirements
Module: i2f_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one int-to-float converter.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for converter completion.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  N_REQ  per-requester conversion request.
REQ-006 req_data  in  N_REQ*32  per-requester signed 32-bit integer operand; slice i is bits [32i+31:32i].
REQ-007 req_ready  out  N_REQ  one-hot accept; transfer on req_valid[i] and req_ready[i].
REQ-008 rsp_valid  out  N_REQ  one-cycle result strobe to the owning requester.
REQ-009 rsp_data  out  32  IEEE-754 single result, shared by all requesters.
REQ-010 rsp_err  out  1  qualifies rsp_valid; 1 means timeout and rsp_data is 0.
REQ-011 cvt_a  out  32  operand to converter, held stable from ISSUE until leaving WAIT.
REQ-012 cvt_start  out  1  one-cycle start pulse to converter.
REQ-013 cvt_done  in  1  converter result strobe.
REQ-014 cvt_z  in  32  converter result, valid with cvt_done.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req_valid is high, grant the round-robin winner g, searching upward from pointer ptr with wrap-around; req_ready[g]=1 combinationally in the same cycle; latch the operand and tag g; next state ISSUE.
REQ-018 req_ready SHALL be all-zero outside IDLE and in IDLE when no request is present.
REQ-019 ISSUE: cvt_start=1 for exactly one cycle; timeout counter cleared; next state WAIT.
REQ-020 WAIT: on cvt_done, latch cvt_z with rsp_err=0 and go to RESP; otherwise increment the counter; when the counter reaches TIMEOUT-1 without cvt_done, go to RESP with rsp_err=1 and a zero result.
REQ-021 cvt_done in a state other than WAIT SHALL be ignored.
REQ-022 RESP: rsp_valid[tag]=1 for one cycle with rsp_data and rsp_err; ptr=(tag+1) mod N_REQ; next state IDLE.
REQ-023 Requesters have no backpressure; the response SHALL NOT be held beyond one cycle.
REQ-024 Latency from accept to rsp_valid SHALL be 3 + converter latency, where converter latency is the number of cycles from cvt_start to cvt_done.
REQ-025 A requester whose req_valid drops before it is granted SHALL be skipped with no state change.
REQ-026 The counter SHALL be ceil(log2(TIMEOUT))+1 bits wide and SHALL NOT wrap.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, ptr=0, counter=0, and all outputs to 0 (req_ready, rsp_valid, rsp_data, rsp_err, cvt_a, cvt_start, busy).
REQ-028 rst asserted mid-operation SHALL abandon the in-flight request with no response; a late cvt_done after reset SHALL be ignored.

Structure
REQ-029 Package fpu_sched_pkg SHALL hold the state enum and the default values of N_REQ and TIMEOUT.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter: inputs request vector and ptr; output one-hot grant and encoded index.

Verification
REQ-031 Single request: req 0 with 32'd1 and a 3-cycle converter -> rsp_valid[0] with 32'h3F800000, rsp_err=0, 6 cycles after accept.
REQ-032 Negative operand: req 1 with 32'hFFFFFFFF -> rsp_valid[1] with 32'hBF800000.
REQ-033 Contention: req 0 and req 2 asserted together with ptr=0 -> grant order 0 then 2; next simultaneous 0/2 request is granted to 0, since ptr=3 wraps to 0.
REQ-034 Fairness: all 4 requesters continuously valid -> grants 0,1,2,3,0 with no starvation.
REQ-035 Timeout: cvt_done never asserted -> rsp_valid with rsp_err=1 and rsp_data=0 after TIMEOUT cycles in WAIT, then back to IDLE.
REQ-036 Reset mid-WAIT: rst=0 for one cycle -> all outputs 0 next cycle, no rsp_valid, and a following cvt_done is ignored.

Source files
------------

// File: rtl/i2f_sched_pkg.sv
// Shared types and defaults for the int-to-float converter scheduler.
package fpu_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/i2f_sched_if.sv
// Requester and converter signals of the scheduler; slave is the scheduler side.
interface i2f_sched_if import fpu_sched_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic [DATA_W-1:0]       cvt_a;
    logic                    cvt_start;
    logic                    cvt_done;
    logic [DATA_W-1:0]       cvt_z;
    logic                    busy;

    modport slave (
        input  req_valid, req_data, cvt_done, cvt_z,
        output req_ready, rsp_valid, rsp_data, rsp_err, cvt_a, cvt_start, busy
    );

    modport master (
        output req_valid, req_data, cvt_done, cvt_z,
        input  req_ready, rsp_valid, rsp_data, rsp_err, cvt_a, cvt_start, busy
    );
endinterface

// File: rtl/i2f_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or above i_ptr, wrapping around.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx
);
    logic             w_found;
    logic [PTR_W-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            w_sel = PTR_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end
endmodule

// File: rtl/i2f_sched.sv
// Shares one external int-to-float converter among N_REQ requesters, with
// round-robin arbitration and a bounded wait for the converter result.
module i2f_sched import fpu_sched_pkg::*; #(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    i2f_sched_if.slave bus
);
    localparam int               PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [PTR_W-1:0]         r_ptr;
    logic [PTR_W-1:0]         r_tag;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_opnd;
    logic [DATA_W-1:0]        r_result;
    logic                     r_err;
    logic [N_REQ-1:0]         r_rsp_valid;
    logic [DATA_W-1:0]        r_rsp_data;
    logic                     r_rsp_err;
    logic [N_REQ-1:0]         w_gnt;
    logic [PTR_W-1:0]         w_gnt_idx;
    logic signed [DATA_W-1:0] w_opnd;
    logic                     w_any;
    logic                     w_timeout;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx)
    );

    assign w_any     = |bus.req_valid;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_opnd = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.cvt_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grants are withheld while reset is asserted so nothing is accepted and then lost.
    always_comb begin
        bus.req_ready = '0;
        bus.cvt_start = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        if (rst && r_state == S_IDLE && w_any) bus.req_ready = w_gnt;
        if (r_state == S_ISSUE)                bus.cvt_start = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_opnd      <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_opnd <= w_opnd;
                        r_tag  <= w_gnt_idx;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // A result arriving on the final allowed cycle still wins over the timeout.
                    if (bus.cvt_done) begin
                        r_result <= bus.cvt_z;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= N_REQ'(1) << r_tag;
                    r_rsp_data  <= r_result;
                    r_rsp_err   <= r_err;
                    r_ptr       <= (r_tag == PTR_W'(N_REQ - 1)) ? '0 : r_tag + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.cvt_a     = r_opnd;
endmodule
